// File: rtl/divide_seq.sv
// Sequential Newton-Raphson divider: unsigned a/b as I(DATA_WD)F(FRA_WD), one reciprocal iteration per clock.
// Optional macro DIVIDE_SEQ_EARLY_EXIT_EN: leave the iteration loop as soon as the reciprocal stops changing.
module divide_seq #(
  parameter int DATA_WD     = 8,
  parameter int FRA_WD      = 8,
  parameter int DATA_INN_WD = 24,
  parameter int NUMB_ITR    = 5
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       val_i,
  output logic                       rdy_o,
  input  logic [DATA_WD-1:0]         dat_a_i,
  input  logic [DATA_WD-1:0]         dat_b_i,
  output logic                       val_o,
  input  logic                       rdy_i,
  output logic [DATA_WD+FRA_WD-1:0]  dat_c_o,
  output logic                       err_o
);

  localparam int TW  = DATA_INN_WD + 1;        // reciprocal t, I1F(DATA_INN_WD)
  localparam int KW  = DATA_INN_WD + 2;        // j and k, I2F(DATA_INN_WD)
  localparam int BTW = DATA_WD + TW;
  localparam int TFW = TW + KW;
  localparam int CFW = DATA_WD + TW;
  localparam int QW  = DATA_WD + FRA_WD;
  localparam int CW  = $clog2(NUMB_ITR + 1);

  localparam logic [TW-1:0] T_ONE = TW'(1) << DATA_INN_WD;
  localparam logic [KW-1:0] K_TWO = KW'(2) << DATA_INN_WD;
  localparam logic [QW-1:0] Q_MAX = '1;

  typedef enum logic [1:0] {IDLE, ITR, MUL, OUT} state_t;

  state_t               state_q, state_d;
  logic [DATA_WD-1:0]   a_q, a_d, b_q, b_d;
  logic [TW-1:0]        t_q, t_d, t0, t_new;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [QW-1:0]        c_d, q_sat;
  logic                 err_d;
  logic [KW-1:0]        j, k;
  logic [TFW-1:0]       tf, tr;
  logic [CFW-1:0]       cf, qr;

  assign rdy_o = (state_q == IDLE);
  assign val_o = (state_q == OUT);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    c_d     = dat_c_o;
    err_d   = err_o;

    // Leading-one seed: t0 = 2^-(p+1) puts b*t0 in [0.5,1); the highest set bit wins.
    t0 = '0;
    for (int i = 0; i < DATA_WD; i++) begin
      if (dat_b_i[i]) t0 = T_ONE >> (i + 1);
    end

    // One Newton-Raphson step t' = t*(2 - b*t), rounded to DATA_INN_WD fraction bits.
    j     = KW'(BTW'(b_q) * BTW'(t_q));
    k     = K_TWO - j;
    tf    = TFW'(t_q) * TFW'(k);
    tr    = ((tf >> (DATA_INN_WD - 1)) + TFW'(1)) >> 1;
    t_new = (tr > TFW'(T_ONE)) ? T_ONE : tr[TW-1:0];

    cf    = CFW'(a_q) * CFW'(t_q);
    qr    = ((cf >> (DATA_INN_WD - FRA_WD - 1)) + CFW'(1)) >> 1;
    q_sat = (qr > CFW'(Q_MAX)) ? Q_MAX : qr[QW-1:0];

    case (state_q)
      IDLE: begin
        if (val_i) begin
          a_d = dat_a_i;
          b_d = dat_b_i;
          if (dat_b_i == '0) begin
            c_d     = Q_MAX;
            err_d   = 1'b1;
            state_d = OUT;
          end else begin
            t_d     = t0;
            cnt_d   = '0;
            state_d = ITR;
          end
        end
      end
      ITR: begin
        t_d   = t_new;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NUMB_ITR - 1)) state_d = MUL;
`ifdef DIVIDE_SEQ_EARLY_EXIT_EN
        if (t_new == t_q) state_d = MUL;
`endif
      end
      MUL: begin
        c_d     = q_sat;
        err_d   = 1'b0;
        state_d = OUT;
      end
      OUT: begin
        if (rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      dat_c_o <= '0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      dat_c_o <= c_d;
      err_o   <= err_d;
    end
  end

endmodule

// File: tb/tb_divide_seq.sv
// Directed bench for divide_seq: hand-computed quotients, latency, stall hold, reset abort, randomised sweep.
module tb_divide_seq;

  localparam int N   = 24;
  localparam int F   = 8;
  localparam int ITR = 5;

  logic        clk = 1'b0;
  logic        rstn;
  logic        val_i, rdy_o, val_o, rdy_i, err_o;
  logic [7:0]  dat_a_i, dat_b_i;
  logic [15:0] dat_c_o;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  int n_ops  = 0;

  divide_seq #(.DATA_WD(8), .FRA_WD(F), .DATA_INN_WD(N), .NUMB_ITR(ITR)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .val_i   (val_i),
    .rdy_o   (rdy_o),
    .dat_a_i (dat_a_i),
    .dat_b_i (dat_b_i),
    .val_o   (val_o),
    .rdy_i   (rdy_i),
    .dat_c_o (dat_c_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rstn && val_o && rdy_i) n_out <= n_out + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_div(input logic [7:0] a, input logic [7:0] b);
    longint unsigned t, j, k, tf, cf, q, m;
    int p;
    if (b == 8'd0) return 16'hFFFF;
    p = 0;
    for (int i = 0; i < 8; i++) if (b[i]) p = i;
    m = 64'd1 << (N + 2);
    t = 64'd1 << (N - p - 1);
    for (int n = 0; n < ITR; n++) begin
      j  = (64'(b) * t) % m;
      k  = ((64'd2 << N) - j) % m;
      tf = t * k;
      t  = ((tf >> (N - 1)) + 64'd1) >> 1;
      if (t > (64'd1 << N)) t = 64'd1 << N;
    end
    cf = 64'(a) * t;
    q  = ((cf >> (N - F - 1)) + 64'd1) >> 1;
    if (q > 64'hFFFF) q = 64'hFFFF;
    return q[15:0];
  endfunction

  // Exact round-half-up of a/b * 2^F; the DUT may differ from it by one LSB.
  function automatic int exact_q(input logic [7:0] a, input logic [7:0] b);
    return (2 * int'(a) * 256 + int'(b)) / (2 * int'(b));
  endfunction

  // Issue one operation, follow it to its handshake. exp_lat < 0 skips the latency check.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall,
                        input int exp_lat, input logic [15:0] exp_c, input logic exp_e,
                        output int lat);
    int guard;
    guard = 0;
    while (!rdy_o && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_rdy", rdy_o, 1);
    dat_a_i = a;
    dat_b_i = b;
    val_i   = 1'b1;
    rdy_i   = (stall == 0);
    @(posedge clk); #1;
    val_i   = 1'b0;
    dat_a_i = 8'($urandom);
    dat_b_i = 8'($urandom);
    lat = 1;
    while (!val_o && lat < 40) begin
      check("busy_rdy", rdy_o, 0);
      @(posedge clk); #1;
      lat++;
    end
    check("val_seen", val_o, 1);
    check("out_rdy", rdy_o, 0);
    if (exp_lat >= 0) check("latency", lat, exp_lat);
    check("quotient", dat_c_o, exp_c);
    check("err", err_o, exp_e);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("hold_val", val_o, 1);
      check("hold_c", dat_c_o, exp_c);
      check("hold_err", err_o, exp_e);
      check("hold_rdy", rdy_o, 0);
    end
    rdy_i = 1'b1;
    @(posedge clk); #1;
    n_ops++;
    check("post_val", val_o, 0);
    check("post_rdy", rdy_o, 1);
  endtask

  int lat;
  int d;
  logic [7:0] ra, rb;

  initial begin
    rstn    = 1'b0;
    val_i   = 1'b0;
    rdy_i   = 1'b1;
    dat_a_i = '0;
    dat_b_i = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", rdy_o, 1);
    check("rst_val", val_o, 0);
    check("rst_c", dat_c_o, 0);
    check("rst_err", err_o, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_op(8'd100, 8'd3, 0, 7, 16'h2155, 1'b0, lat);
    check("model_100_3", 16'h2155, model_div(8'd100, 8'd3));
    run_op(8'd255, 8'd1, 0, 7, 16'hFF00, 1'b0, lat);
    run_op(8'd1, 8'd255, 0, 7, 16'h0001, 1'b0, lat);
    run_op(8'd37, 8'd0, 0, 1, 16'hFFFF, 1'b1, lat);
    run_op(8'd200, 8'd7, 4, 7, 16'h1C92, 1'b0, lat);
    run_op(8'd0, 8'd5, 0, 7, 16'h0000, 1'b0, lat);
    run_op(8'd255, 8'd255, 1, 7, 16'h0100, 1'b0, lat);
    run_op(8'd255, 8'd254, 0, 7, 16'h0101, 1'b0, lat);
    run_op(8'd255, 8'd128, 2, 7, 16'h01FE, 1'b0, lat);
    run_op(8'd200, 8'd7, 0, 7, 16'h1C92, 1'b0, lat);

    // Abort mid-iteration: reset lands in the third ITR cycle.
    dat_a_i = 8'd200;
    dat_b_i = 8'd7;
    val_i   = 1'b1;
    @(posedge clk); #1;
    val_i = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("abort_rdy", rdy_o, 1);
    check("abort_val", val_o, 0);
    check("abort_c", dat_c_o, 0);
    check("abort_err", err_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_val", val_o, 0);
    check("abort_no_out", n_out, n_ops);

    run_op(8'd100, 8'd3, 0, 7, 16'h2155, 1'b0, lat);

`ifdef DIVIDE_SEQ_EARLY_EXIT_EN
    run_op(8'd128, 8'd128, 0, -1, 16'h0100, 1'b0, lat);
    check("early_lat_range", (lat >= 3 && lat <= ITR + 2), 1);
`endif

    for (int n = 0; n < 300; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_op(ra, rb, $urandom_range(0, 2),
`ifdef DIVIDE_SEQ_EARLY_EXIT_EN
             (rb == 8'd0) ? 1 : -1,
`else
             (rb == 8'd0) ? 1 : ITR + 2,
`endif
             model_div(ra, rb), (rb == 8'd0), lat);
      if (rb != 8'd0) begin
        d = int'(dat_c_o) - exact_q(ra, rb);
        check("within_1lsb", (d >= -1 && d <= 1), 1);
      end
    end

    @(posedge clk); #1;
    check("ops_vs_results", n_out, n_ops);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
